// File: rtl/corescore_stream_fifo.sv
// -----------------------------------------------------------------------------
// corescore_stream_fifo
//
// Byte-wide AXI-Stream style FIFO between the score generator and the UART
// emitter. Each entry stores {tlast, tdata}. With PACKET_MODE=1 the output is
// held back until at least one complete packet (a stored tlast beat) is
// present. It is also released when the FIFO is full, so that packets longer
// than the FIFO cannot deadlock. With PACKET_MODE=0 it is a plain
// first-word-fall-through FIFO.
//
// Parameters
//   DEPTH_LOG2   depth = 2**DEPTH_LOG2 beats (1..10)
//   PACKET_MODE  1 = packet-gated output, 0 = plain FIFO
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_tdata/i_tlast/i_tvalid    upstream beat
//   o_tready                    FIFO can accept a beat (registered)
//   o_tdata/o_tlast/o_tvalid    downstream beat (entry at the read pointer)
//   i_tready                    downstream accepts a beat
//   o_count                     beats currently stored
//   o_packets                   tlast beats currently stored
// -----------------------------------------------------------------------------
module corescore_stream_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter bit PACKET_MODE = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_tdata,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  output logic                  o_tready,
  output logic [7:0]            o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [DEPTH_LOG2:0]   o_packets
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0] ptr_t;

  localparam ptr_t FULL_COUNT = ptr_t'(DEPTH);
  localparam ptr_t ONE        = ptr_t'(1);

  logic [8:0] mem [DEPTH];

  ptr_t wr_ptr, rd_ptr;
  ptr_t count_q, count_d;
  ptr_t packets_q, packets_d;
  logic tready_q;
  logic wr_en, rd_en;
  logic [8:0] rd_word;

  assign wr_en = i_tvalid && tready_q;
  assign rd_en = o_tvalid && i_tready;

  // First-word fall-through: the head entry is always presented.
  assign rd_word = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign o_tdata = rd_word[7:0];
  assign o_tlast = rd_word[8];

  // The full-FIFO clause releases oversized packets. Otherwise such a packet
  // would block forever waiting for its tlast.
  assign o_tvalid = (count_q != '0) &&
                    (!PACKET_MODE || (packets_q != '0) || (count_q == FULL_COUNT));

  assign o_tready  = tready_q;
  assign o_count   = count_q;
  assign o_packets = packets_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_d   = count_q;
    packets_d = packets_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    if (wr_en && i_tlast) packets_d = packets_d + ONE;
    if (rd_en && o_tlast) packets_d = packets_d - ONE;
  end

  // o_tready is registered from the next count. It therefore depends only on
  // state, and it stays low while reset is asserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: state registers use non-blocking assignments so that every
      // flop samples the pre-edge values regardless of statement order.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      packets_q <= '0;
      tready_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      count_q   <= count_d;
      packets_q <= packets_d;
      tready_q  <= (count_d < FULL_COUNT);
    end
  end

  // NOTE: the storage array is deliberately not reset. Clearing the pointers
  // and counters is enough to discard its contents, and a reset-free array
  // can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {i_tlast, i_tdata};
  end

endmodule
